// File: rtl/manq_uart_pkg.sv
// Shared UART types and line levels for the transmitter and the future receiver.
// Parity support is compiled in with UART_TX_PARITY_EN.
package manq_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-time divider: tick_o marks the last clock of every bit time.
// clear_i holds the count at zero so a new frame starts on a full bit.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake and a registered line output.
// Define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | one bit time low
// DATA   | eight bit times, LSB first
// PARITY | one bit time of even parity (UART_TX_PARITY_EN only)
// STOP   | one bit time high, then back to IDLE
module uart_tx
    import manq_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    uart_tx_state_e state_q;
    logic [7:0]     shift_q;
    logic [2:0]     bit_cnt_q;
    logic           tx_q;
    logic           tick;
    logic           accept;
`ifdef UART_TX_PARITY_EN
    logic           parity_q;
`endif

    assign ready_o = (state_q == IDLE);
    assign busy_o  = ~ready_o;
    assign tx_o    = tx_q;
    assign accept  = valid_i && ready_o;

    // Holding the divider clear while idle guarantees the start bit gets a full bit time.
    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(ready_o),
        .tick_o (tick)
    );

    // tx_q is loaded with the level of the bit being entered, so the pin stays flop-driven.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shift_q   <= data_i;
                        bit_cnt_q <= '0;
                        tx_q      <= START_LEVEL;
                        state_q   <= START;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^data_i;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= STOP_LEVEL;
                            state_q <= STOP;
`endif
                        end else begin
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx_q    <= STOP_LEVEL;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        tx_q    <= IDLE_LEVEL;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= IDLE_LEVEL;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4; honours UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .data_i (data),
        .valid_i(valid),
        .ready_o(ready),
        .tx_o   (tx),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Expected line levels per bit time: start, 8 data bits LSB first, [parity], stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        f = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int v;
            v = (int'(b) >> i) % 2;
            f[i + 1] = (v == 1);
            ones += v;
        end
`ifdef UART_TX_PARITY_EN
        f[9] = (ones % 2 == 1);
`endif
        return f;
    endfunction

    // Waits (bounded) for ready, presents the byte, returns at the first start-bit cycle.
    task automatic start_frame(input logic [7:0] b, input bit hold, output bit ok);
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = (ready === 1'b1);
        data  = b;
        valid = 1'b1;
        @(negedge clk);
        if (!hold) valid = 1'b0;
    endtask

    // Samples tx mid-bit until ready returns; len is cycles from first start cycle to ready.
    task automatic capture_frame(input bit disturb, input bit hold,
                                 output logic [10:0] bits, output int len, output int nbusy);
        bits  = '1;
        len   = 0;
        nbusy = 0;
        while (ready !== 1'b1 && len < NB * CPB + 40) begin
            if (len % CPB == 1 && len / CPB < 11) bits[len / CPB] = tx;
            if (busy !== 1'b1) nbusy++;
            if (disturb) begin
                data  = 8'($urandom);
                valid = 1'($urandom);
            end
            @(negedge clk);
            len++;
        end
        if (!hold) valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({tx, ready, busy} !== 3'b110) begin
                bad++;
                $display("FAIL reset_idle cycle %0d got tx/ready/busy=%b want=110", i, {tx, ready, busy});
            end
        end
    endtask

    task automatic test_single();
        logic [10:0] bits, expv;
        int len, nbusy;
        bit ok;
        start_frame(8'hA5, 1'b0, ok);
        capture_frame(1'b0, 1'b0, bits, len, nbusy);
        expv = model_frame(8'hA5);
        total++;
        if (!ok || bits !== expv) begin
            bad++;
            $display("FAIL single_a5_bits got=%b want=%b ok=%0d", bits, expv, ok);
        end
        total++;
        if (len != NB * CPB) begin
            bad++;
            $display("FAIL single_a5_len got=%0d want=%0d", len, NB * CPB);
        end
        total++;
        if (nbusy != 0) begin
            bad++;
            $display("FAIL single_a5_busy got=%0d not-busy cycles want=0", nbusy);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits, expv;
        int len, nbusy;
        bit ok;
        start_frame(8'h00, 1'b1, ok);
        capture_frame(1'b0, 1'b1, bits, len, nbusy);
        expv = model_frame(8'h00);
        total++;
        if (!ok || bits !== expv || len != NB * CPB) begin
            bad++;
            $display("FAIL b2b_first got=%b len=%0d want=%b len=%0d", bits, len, expv, NB * CPB);
        end
        total++;
        if (tx !== 1'b1 || ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gap got tx=%b ready=%b want tx=1 ready=1", tx, ready);
        end
        data = 8'hFF;
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || tx !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap_len got ready=%b tx=%b want ready=0 tx=0", ready, tx);
        end
        valid = 1'b0;
        capture_frame(1'b0, 1'b0, bits, len, nbusy);
        expv = model_frame(8'hFF);
        total++;
        if (bits !== expv || len != NB * CPB) begin
            bad++;
            $display("FAIL b2b_second got=%b len=%0d want=%b len=%0d", bits, len, expv, NB * CPB);
        end
    endtask

    task automatic test_ignore_midframe();
        logic [10:0] bits, expv;
        int len, nbusy;
        bit ok;
        start_frame(8'h5A, 1'b0, ok);
        capture_frame(1'b1, 1'b0, bits, len, nbusy);
        expv = model_frame(8'h5A);
        total++;
        if (!ok || bits !== expv || len != NB * CPB) begin
            bad++;
            $display("FAIL ignore_midframe got=%b len=%0d want=%b len=%0d", bits, len, expv, NB * CPB);
        end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] bits, expv;
        int len, nbusy;
        bit ok;
        start_frame(8'h3C, 1'b0, ok);
        repeat (4 * CPB + 2) @(negedge clk);
        total++;
        if (!ok || tx !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL pre_reset_bit3 got tx=%b ready=%b want tx=1 ready=0", tx, ready);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({tx, ready, busy} !== 3'b110) begin
            bad++;
            $display("FAIL async_reset got tx/ready/busy=%b want=110", {tx, ready, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(8'h81, 1'b0, ok);
        capture_frame(1'b0, 1'b0, bits, len, nbusy);
        expv = model_frame(8'h81);
        total++;
        if (!ok || bits !== expv || len != NB * CPB) begin
            bad++;
            $display("FAIL post_reset_81 got=%b len=%0d want=%b len=%0d", bits, len, expv, NB * CPB);
        end
    endtask

    task automatic test_random();
        logic [10:0] bits, expv;
        logic [7:0]  b;
        int len, nbusy;
        bit ok;
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b = 8'($urandom);
            start_frame(b, 1'b0, ok);
            capture_frame(1'b0, 1'b0, bits, len, nbusy);
            expv = model_frame(b);
            total++;
            if (!ok || bits !== expv || len != NB * CPB || nbusy != 0) begin
                bad++;
                $display("FAIL random_%02h got=%b len=%0d nbusy=%0d want=%b len=%0d",
                         b, bits, len, nbusy, expv, NB * CPB);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [10:0] bits;
        int len, nbusy;
        bit ok;
        start_frame(8'h07, 1'b0, ok);
        capture_frame(1'b0, 1'b0, bits, len, nbusy);
        total++;
        if (!ok || bits[9] !== 1'b1 || bits[10] !== 1'b1 || len != 44) begin
            bad++;
            $display("FAIL parity_07 got par=%b stop=%b len=%0d want par=1 stop=1 len=44",
                     bits[9], bits[10], len);
        end
        start_frame(8'hA5, 1'b0, ok);
        capture_frame(1'b0, 1'b0, bits, len, nbusy);
        total++;
        if (!ok || bits[9] !== 1'b0 || len != 44) begin
            bad++;
            $display("FAIL parity_a5 got par=%b len=%0d want par=0 len=44", bits[9], len);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        #12 rst_n = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
